// File: rtl/seg_memory_access_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_memory_access_pkg : shared MIPS widths, MEM control-bus layout and   |
// | load/store lane helpers.                          Revision: 1.0          |
// +--------------------------------------------------------------------------+
package seg_memory_access_pkg;

  localparam int C_LEN          = 32;
  localparam int C_NB_ADDR      = 5;
  localparam int C_NB_CTRL_WB   = 2;
  localparam int C_NB_CTRL_MEM  = 5;
  localparam int C_NB_DMEM_ADDR = 7;

  localparam int C_MEM_READ_BIT  = 4;
  localparam int C_MEM_WRITE_BIT = 3;
  localparam int C_SIZE_MSB      = 2;
  localparam int C_SIZE_LSB      = 1;
  localparam int C_UNSIGNED_BIT  = 0;

  typedef enum logic [1:0] {
    SIZE_BYTE     = 2'b00,
    SIZE_HALF     = 2'b01,
    SIZE_WORD_ALT = 2'b10,
    SIZE_WORD     = 2'b11
  } mem_size_e;

  function automatic logic [3:0] lane_enables(input mem_size_e size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 4'b0001 << offset;
      SIZE_HALF: return offset[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [C_LEN-1:0] extend_lane(input logic [C_LEN-1:0] word,
                                                   input mem_size_e        size,
                                                   input logic [1:0]       offset,
                                                   input logic             is_unsigned);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b = word[8*offset +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: return is_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SIZE_HALF: return is_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default:   return word;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_memory_access_data_memory.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_memory : word-organised RAM, byte-lane write enables, async read    |
// | port plus async debug read port; contents never reset.  Revision: 1.0    |
// +--------------------------------------------------------------------------+
module data_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 7
) (
  input  logic                 i_clk,
  input  logic [NB_DATA/8-1:0] i_byte_we,
  input  logic [NB_ADDR-1:0]   i_addr,
  input  logic [NB_DATA-1:0]   i_wdata,
  output logic [NB_DATA-1:0]   o_rdata,
  input  logic [NB_ADDR-1:0]   i_debug_addr,
  output logic [NB_DATA-1:0]   o_debug_data
);

  localparam int C_DEPTH = 1 << NB_ADDR;
  localparam int C_LANES = NB_DATA / 8;

  logic [NB_DATA-1:0] mem_q [C_DEPTH];

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < C_LANES; k++) begin
      if (i_byte_we[k]) begin
        mem_q[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
      end
    end
  end

  assign o_rdata      = mem_q[i_addr];
  assign o_debug_data = mem_q[i_debug_addr];

endmodule
`default_nettype wire

// File: rtl/seg_memory_access.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seg_memory_access : MIPS MEM stage - lane select/extend, data memory and |
// | MEM/WB pipeline latch.                            Revision: 1.0          |
// +--------------------------------------------------------------------------+
module seg_memory_access
  import seg_memory_access_pkg::*;
#(
  parameter int LEN          = C_LEN,
  parameter int NB_ADDR      = C_NB_ADDR,
  parameter int NB_CTRL_WB   = C_NB_CTRL_WB,
  parameter int NB_CTRL_MEM  = C_NB_CTRL_MEM,
  parameter int NB_DMEM_ADDR = C_NB_DMEM_ADDR
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_enable,
  input  logic [LEN-1:0]          i_ALU_result,
  input  logic [LEN-1:0]          i_write_data,
  input  logic [NB_ADDR-1:0]      i_write_register,
  input  logic [NB_CTRL_MEM-1:0]  i_ctrl_mem_bus,
  input  logic [NB_CTRL_WB-1:0]   i_ctrl_wb_bus,
  input  logic [NB_DMEM_ADDR-1:0] i_debug_addr,
  output logic [LEN-1:0]          o_read_data,
  output logic [LEN-1:0]          o_ALU_result,
  output logic [NB_ADDR-1:0]      o_write_register,
  output logic [NB_CTRL_WB-1:0]   o_ctrl_wb_bus,
  output logic [LEN-1:0]          o_debug_data
);

  logic [NB_DMEM_ADDR-1:0] word_idx;
  logic [1:0]              offset;
  mem_size_e               size;
  logic [3:0]              lane_we;
  logic [LEN-1:0]          store_word;
  logic [LEN-1:0]          mem_word;

  logic [LEN-1:0]        read_data_d,  read_data_q;
  logic [LEN-1:0]        alu_result_d, alu_result_q;
  logic [NB_ADDR-1:0]    write_reg_d,  write_reg_q;
  logic [NB_CTRL_WB-1:0] ctrl_wb_d,    ctrl_wb_q;

  // The load path always reads regardless of MemRead, so that bit is not needed here.
  logic unused_mem_read;
  assign unused_mem_read = i_ctrl_mem_bus[C_MEM_READ_BIT];

  always_comb begin
    word_idx = i_ALU_result[NB_DMEM_ADDR+1:2];
    offset   = i_ALU_result[1:0];
    size     = mem_size_e'(i_ctrl_mem_bus[C_SIZE_MSB:C_SIZE_LSB]);

    lane_we = 4'b0000;
    if (i_enable && !i_rst && i_ctrl_mem_bus[C_MEM_WRITE_BIT]) begin
      lane_we = lane_enables(size, offset);
    end

    // Replicate the low byte/half across all lanes; the lane enables pick the target.
    case (size)
      SIZE_BYTE: store_word = {4{i_write_data[7:0]}};
      SIZE_HALF: store_word = {2{i_write_data[15:0]}};
      default:   store_word = i_write_data;
    endcase

    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    write_reg_d  = write_reg_q;
    ctrl_wb_d    = ctrl_wb_q;
    if (i_enable) begin
      read_data_d  = extend_lane(mem_word, size, offset, i_ctrl_mem_bus[C_UNSIGNED_BIT]);
      alu_result_d = i_ALU_result;
      write_reg_d  = i_write_register;
      ctrl_wb_d    = i_ctrl_wb_bus;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      read_data_q  <= '0;
      alu_result_q <= '0;
      write_reg_q  <= '0;
      ctrl_wb_q    <= '0;
    end else begin
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
      ctrl_wb_q    <= ctrl_wb_d;
    end
  end

  data_memory #(
    .NB_DATA (LEN),
    .NB_ADDR (NB_DMEM_ADDR)
  ) u_data_memory (
    .i_clk        (i_clk),
    .i_byte_we    (lane_we),
    .i_addr       (word_idx),
    .i_wdata      (store_word),
    .o_rdata      (mem_word),
    .i_debug_addr (i_debug_addr),
    .o_debug_data (o_debug_data)
  );

  assign o_read_data      = read_data_q;
  assign o_ALU_result     = alu_result_q;
  assign o_write_register = write_reg_q;
  assign o_ctrl_wb_bus    = ctrl_wb_q;

endmodule
`default_nettype wire

// File: doc/seg_memory_access.md
SEG_MEMORY_ACCESS -- requirements
Module: seg_memory_access

Interface
REQ-001 Parameters SHALL be: LEN 32, datapath width; NB_ADDR 5, register-file address width; NB_CTRL_WB 2, WB control width; NB_CTRL_MEM 5, MEM control width; NB_DMEM_ADDR 7, data-memory word-address width (128 words).
REQ-002 Ports SHALL be, one per line:
- i_clk  in  1  single clock; all state updates on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_enable  in  1  pipeline advance; 0 freezes all state.
- i_ALU_result  in  LEN  effective byte address / ALU value from EX/MEM.
- i_write_data  in  LEN  store data (rt value).
- i_write_register  in  NB_ADDR  destination register.
- i_ctrl_mem_bus  in  NB_CTRL_MEM  [4]MemRead, [3]MemWrite, [2:1]size (00 byte, 01 half, 11 word, 10 treated as word), [0]unsigned-load.
- i_ctrl_wb_bus  in  NB_CTRL_WB  [RegWrite, MemtoReg], passed through.
- i_debug_addr  in  NB_DMEM_ADDR  debug word address.
- o_read_data  out  LEN  registered, extended load data.
- o_ALU_result  out  LEN  registered i_ALU_result.
- o_write_register  out  NB_ADDR  registered i_write_register.
- o_ctrl_wb_bus  out  NB_CTRL_WB  registered i_ctrl_wb_bus.
- o_debug_data  out  LEN  combinational word read at i_debug_addr.

Function
REQ-003 Word index SHALL be i_ALU_result[NB_DMEM_ADDR+1:2]; higher address bits ignored (wrap modulo 128 words).
REQ-004 Byte lanes SHALL be little-endian: lane k = bits 8k+7:8k, k = i_ALU_result[1:0].
REQ-005 Halfword lane SHALL be selected by i_ALU_result[1] (0: bits 15:0, 1: bits 31:16); bit 0 ignored; word access ignores bits 1:0.
REQ-006 Store: when i_enable & MemWrite at a rising edge, memory SHALL update only the selected lanes with i_write_data low byte/half/word; other lanes unchanged.
REQ-007 Load: o_read_data SHALL be the selected lane from the pre-edge memory contents, zero-extended if unsigned=1, else sign-extended, registered at the same edge (latency 1 cycle from inputs).
REQ-008 When MemRead=0, o_read_data SHALL still register the extended lane value (don't-care to WB but deterministic).
REQ-009 MemRead and MemWrite both 1, same address: write SHALL occur, o_read_data SHALL return old contents.
REQ-010 o_ALU_result, o_write_register, o_ctrl_wb_bus SHALL register their inputs each enabled edge (latency 1).
REQ-011 i_enable=0 SHALL block memory writes and hold all registered outputs.
REQ-012 o_debug_data SHALL reflect memory contents combinationally, including a write completed at the previous edge.

Reset
REQ-013 On i_rst=1 at a rising edge, o_read_data, o_ALU_result, o_write_register, o_ctrl_wb_bus SHALL become 0, regardless of i_enable.
REQ-014 Reset SHALL have priority over enable and SHALL suppress any concurrent store.
REQ-015 Data-memory contents SHALL NOT be cleared by reset.

Structure
REQ-016 Control-bus bit positions, size encodings and widths (LEN, NB_ADDR, NB_CTRL_WB, NB_CTRL_MEM) SHALL live in the shared MIPS parameters package.
REQ-017 Data memory SHALL be a sub-module data_memory (byte-lane write enables, async read, debug read port); the MEM/WB latch and lane/extension logic stay in seg_memory_access.

Verification
REQ-018 Reset then idle -> all registered outputs 0 after first edge with i_rst=1.
REQ-019 SW 0xDEADBEEF at 0x10, then LW 0x10 -> o_read_data 0xDEADBEEF one cycle after the load; o_debug_data at word 4 = 0xDEADBEEF.
REQ-020 SB 0x7F at 0x11 over 0xDEADBEEF, then LB/LBU at 0x13 -> 0xFFFFFFDE / 0x000000DE; word 4 = 0xDEAD7FEF.
REQ-021 SH 0x8001 at 0x22, LH 0x22 -> 0xFFFF8001, LHU -> 0x00008001; lower half of word 8 unchanged.
REQ-022 i_enable=0 with SW 0x12345678 at 0x00 and changed pass-through inputs -> memory word 0 unchanged, outputs held; address 0x200 store writes word 0 (wrap).
REQ-023 i_rst=1 concurrent with SW 0xFFFFFFFF at 0x10 -> outputs 0, word 4 unchanged; i_ctrl_wb_bus 2'b11, i_write_register 5'd7 -> outputs 2'b11, 5'd7 one cycle later.
